des_subkey_gen: RTL and testbench
=================================

Name: des_subkey_gen

Overview:
Sequential DES key-schedule engine. It takes a 64-bit key and streams the 16 round subkeys (48 bits each), one per handshake, to the round datapath. In encrypt mode it streams K1..K16 using left rotations. In decrypt mode it streams K16..K1 using right rotations, so the reverse order is produced without storing the full schedule. It sits between the key register and the DES round core, and one instance serves each DES stage of the 3DES pipeline.

Parameters:
- None. Block is fixed to FIPS 46-3 DES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- start  input  1  request a new schedule; accepted only in IDLE
- mode  input  1  0 = encrypt order (K1..K16), 1 = decrypt order (K16..K1); sampled with start
- key64  input  64  DES key, bit 63 = FIPS bit 1; parity bits (FIPS 8,16,..,64) ignored; sampled with start
- next  input  1  consumer accepts the current subkey (meaningful only while subkey_valid)
- subkey  output  48  current round key, bit 47 = FIPS PC-2 output bit 1
- subkey_valid  output  1  subkey holds a valid key
- round_idx  output  4  stream position 0..15 (0 = first key delivered, in either mode)
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse after the 16th key is accepted

Behaviour:
- Reset: rst_n low at a clock edge forces state IDLE, C/D registers = 0, subkey_valid = 0, round_idx = 0, busy = 0, done = 0, and subkey = 0 (subkey = PC-2 of zeroed C/D).
- Reset mid-stream aborts the stream. There is no residual output after reset.
- States: IDLE, RUN.
- Internal registers: C[27:0], D[27:0], mode_r, cnt[3:0].
- subkey = PC-2(C,D), combinational from registers only. There is no combinational path from any input to any output.
- Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- IDLE + start, cycle T:
  - {C0,D0} = PC-1(key64).
  - Encrypt: C,D <= rotl(C0,1), rotl(D0,1), i.e. the K1 state.
  - Decrypt: C,D <= C0,D0. This is the K16 state, since the total shift is 28.
  - mode_r <= mode, cnt <= 0, state <= RUN.
  - Result: subkey_valid = 1 at T+1 and busy = 1 from T+1.
- RUN with subkey_valid && !next: C, D and cnt hold. subkey and round_idx stay stable indefinitely.
- RUN with subkey_valid && next, cnt < 15: cnt <= cnt+1. The next key is valid the following cycle, so throughput is 1 key/cycle with next held high.
  - Encrypt: rotate left by s[cnt+2].
  - Decrypt: rotate right by s[16-cnt].
- RUN with next and cnt == 15: state <= IDLE, subkey_valid <= 0, done <= 1 for exactly one cycle, cnt <= 0.
- round_idx = cnt.
- start while busy is ignored. mode and key64 changes while busy have no effect.
- start in the done cycle is accepted (state is already IDLE).
- next while !subkey_valid is ignored.
- Latency: first key 1 cycle after start. Full stream with next tied high takes 16 cycles, done at T+17.
- All rotations are modulo 28 within each half. No cross-half carry.

Test Plan:
- Encrypt, key64 = 0x133457799BBCDFF1, start at T, next = 1 →
  - valid T+1..T+16.
  - round 0 = 0x1B02EFFC7072, round 1 = 0x79AED9DBC9E5, round 15 = 0xCB3D8B0E17F5.
  - done = 1 only at T+17; busy low at T+17.
- Decrypt, same key →
  - round 0 = 0xCB3D8B0E17F5, round 1 = 0xBF918D3D3F0A, round 15 = 0x1B02EFFC7072.
  - Full sequence equals the encrypt sequence reversed.
- Stall: encrypt, drop next for 5 cycles at round_idx = 3 →
  - subkey and round_idx unchanged over those cycles.
  - Stream completes with identical 16 keys; done 5 cycles later than in the unstalled run.
- Start while busy: pulse start with a different key64 and mode at round_idx = 7 → stream unaffected, 16 original keys delivered.
- Reset mid-stream: rst_n = 0 at round_idx = 9 →
  - next cycle: subkey_valid = 0, busy = 0, subkey = 0, done = 0.
  - A new start then delivers a full correct 16-key stream.
- Parity ignored: key64 = 0x123556789ABDDEF0 → identical subkeys to 0x133457799BBCDFF1 in both modes; back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/des_subkey_gen_if.sv
// Handshake bundle between the DES key-schedule engine and its round-datapath consumer.
interface des_subkey_gen_if;
    localparam int unsigned KEY_W = 64;
    localparam int unsigned SK_W  = 48;
    localparam int unsigned CNT_W = 4;

    logic             start;
    logic             mode;
    logic [KEY_W-1:0] key64;
    logic             next;
    logic [SK_W-1:0]  subkey;
    logic             subkey_valid;
    logic [CNT_W-1:0] round_idx;
    logic             busy;
    logic             done;

    // Requester / consumer side
    modport master (
        output start, mode, key64, next,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    // Key-schedule engine side
    modport slave (
        input  start, mode, key64, next,
        output subkey, subkey_valid, round_idx, busy, done
    );
endinterface

// File: rtl/des_subkey_gen.sv
// Sequential DES key schedule: streams K1..K16 (encrypt) or K16..K1 (decrypt), one per handshake.
module des_subkey_gen (
    input  logic            clk,
    input  logic            rst_n,
    des_subkey_gen_if.slave bus
);
    localparam int unsigned HALF_W = 28;
    localparam int unsigned CD_W   = 56;
    localparam int unsigned KEY_W  = 64;
    localparam int unsigned SK_W   = 48;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SIDX_W = 5;

    // PC-1: entry j (0 = first) is the FIPS key bit feeding C/D bit j+1
    localparam logic [CD_W*IDX_W-1:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    // PC-2: entry j is the C/D bit (1-based) feeding subkey bit j+1
    localparam logic [SK_W*IDX_W-1:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   c_q, c_d;
    logic [HALF_W-1:0]   d_q, d_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [CD_W-1:0]     cd0;
    logic                enc_two;
    logic                dec_two;

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
        logic [CD_W-1:0] r;
        int p;
        r = '0;
        for (int j = 0; j < int'(CD_W); j++) begin
            p = int'(PC1_TAB[(int'(CD_W) - 1 - j) * int'(IDX_W) +: IDX_W]);
            r[int'(CD_W) - 1 - j] = k[int'(KEY_W) - p];
        end
        return r;
    endfunction

    function automatic logic [SK_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SK_W-1:0] r;
        int p;
        r = '0;
        for (int j = 0; j < int'(SK_W); j++) begin
            p = int'(PC2_TAB[(int'(SK_W) - 1 - j) * int'(IDX_W) +: IDX_W]);
            r[int'(SK_W) - 1 - j] = cd[int'(CD_W) - p];
        end
        return r;
    endfunction

    // Shift amount for schedule step idx (1..16): steps 1, 2, 9, 16 move by one, the rest by two
    function automatic logic shift_two(input logic [SIDX_W-1:0] idx);
        return !((idx == 5'd1) || (idx == 5'd2) || (idx == 5'd9) || (idx == 5'd16));
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

    // Next-state and register updates; decrypt walks backwards by undoing each step's shift
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        cd0     = pc1(bus.key64);
        enc_two = shift_two(SIDX_W'(cnt_q) + 5'd2);
        dec_two = shift_two(5'd16 - SIDX_W'(cnt_q));
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.mode;
                    cnt_d   = '0;
                    state_d = RUN;
                    if (bus.mode) begin
                        c_d = cd0[CD_W-1:HALF_W];
                        d_d = cd0[HALF_W-1:0];
                    end else begin
                        c_d = rotl(cd0[CD_W-1:HALF_W], 1'b0);
                        d_d = rotl(cd0[HALF_W-1:0], 1'b0);
                    end
                end
            end
            RUN: begin
                if (bus.next) begin
                    if (cnt_q == 4'd15) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (mode_q) begin
                            c_d = rotr(c_q, dec_two);
                            d_d = rotr(d_q, dec_two);
                        end else begin
                            c_d = rotl(c_q, enc_two);
                            d_d = rotl(d_q, enc_two);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and schedule registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.subkey       = pc2({c_q, d_q});
    assign bus.subkey_valid = (state_q == RUN);
    assign bus.busy         = (state_q == RUN);
    assign bus.round_idx    = cnt_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_des_subkey_gen.sv
// Self-checking bench for des_subkey_gen against an array-based DES key-schedule model.
module tb_des_subkey_gen;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    des_subkey_gen_if bus();

    des_subkey_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
                       10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
                       63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
                       14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    int PC2_T [48] = '{14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
                       23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
                       41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                       44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;

    logic [47:0] ref_k [16];
    logic [47:0] obs_k [16];
    int          obs_n;
    int          done_c;
    bit          idx_ok, stall_ok, timed_out;
    logic        first_valid, busy_first, busy_at_done, valid_at_done, done_after;

    // Reference schedule: each Kr is PC-2 of C0/D0 rotated left by the cumulative shift count
    task automatic compute_ref(input logic [63:0] key);
        bit c0 [28];
        bit d0 [28];
        int tot;
        int p;
        logic [47:0] k;
        for (int j = 0; j < 28; j++) begin
            c0[j] = key[64 - PC1_T[j]];
            d0[j] = key[64 - PC1_T[j + 28]];
        end
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            k = '0;
            for (int m = 0; m < 48; m++) begin
                p = PC2_T[m];
                if (p <= 28) k[47 - m] = c0[(p - 1 + tot) % 28];
                else         k[47 - m] = d0[(p - 29 + tot) % 28];
            end
            ref_k[r] = k;
        end
    endtask

    // Drives one stream and records what the DUT delivers; scenario tasks judge the record
    task automatic drive_stream(input logic [63:0] key, input logic md, input bit do_start,
                                input int stall_at, input int stall_len, input bit alt_start,
                                input bit rand_next, input bit chain,
                                input logic [63:0] chain_key, input logic chain_md);
        int c, stall_left;
        bit stalled, alt_done, check_held;
        logic [47:0] held_k;
        logic [3:0]  held_i;
        obs_n = 0; done_c = -1; idx_ok = 1; stall_ok = 1; timed_out = 1;
        first_valid = 1'b0; busy_first = 1'b0; busy_at_done = 1'b1; valid_at_done = 1'b1;
        done_after = 1'b1;
        stall_left = 0; stalled = 0; alt_done = 0; check_held = 0; held_k = '0; held_i = '0;
        if (do_start) begin
            bus.start = 1'b1; bus.mode = md; bus.key64 = key;
        end
        bus.next = 1'b0;
        c = 0;
        while (c < 200) begin
            @(posedge clk); #1;
            c++;
            bus.start = 1'b0;
            bus.next  = 1'b0;
            if (c == 1) begin
                first_valid = bus.subkey_valid;
                busy_first  = bus.busy;
            end
            if (bus.done) begin
                done_c = c; busy_at_done = bus.busy; valid_at_done = bus.subkey_valid;
                timed_out = 0;
                if (chain) begin
                    bus.start = 1'b1; bus.mode = chain_md; bus.key64 = chain_key;
                end
                break;
            end
            if (bus.subkey_valid) begin
                if (check_held && (bus.subkey !== held_k || bus.round_idx !== held_i)) stall_ok = 0;
                if (stall_len > 0 && !stalled && bus.round_idx == 4'(stall_at)) begin
                    stalled = 1; stall_left = stall_len; check_held = 1;
                    held_k = bus.subkey; held_i = bus.round_idx;
                end
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    check_held = 0;
                    bus.next = rand_next ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (bus.next) begin
                        if (obs_n < 16) begin
                            obs_k[obs_n] = bus.subkey;
                            if (bus.round_idx !== 4'(obs_n)) idx_ok = 0;
                        end
                        obs_n++;
                    end
                end
                if (alt_start && !alt_done && bus.round_idx == 4'd7) begin
                    bus.start = 1'b1; bus.mode = ~md; bus.key64 = ~key; alt_done = 1;
                end
            end
        end
        if (!chain && !timed_out) begin
            @(posedge clk); #1;
            done_after = bus.done;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.key64 = '0; bus.next = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.subkey_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.subkey_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.subkey !== 48'h0) begin failures++; $display("FAIL reset_subkey got=%h want=0", bus.subkey); end
        checks++; if (bus.round_idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", bus.round_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt;
        compute_ref(KEY_A);
        drive_stream(KEY_A, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL enc_timeout got=no_done want=done"); end
        checks++; if (first_valid !== 1'b1 || busy_first !== 1'b1) begin failures++; $display("FAIL enc_latency got=valid%b busy%b want=1 1", first_valid, busy_first); end
        checks++; if (obs_n !== 16) begin failures++; $display("FAIL enc_count got=%0d want=16", obs_n); end
        checks++; if (obs_k[0] !== 48'h1B02EFFC7072) begin failures++; $display("FAIL enc_k1 got=%h want=1b02effc7072", obs_k[0]); end
        checks++; if (obs_k[1] !== 48'h79AED9DBC9E5) begin failures++; $display("FAIL enc_k2 got=%h want=79aed9dbc9e5", obs_k[1]); end
        checks++; if (obs_k[15] !== 48'hCB3D8B0E17F5) begin failures++; $display("FAIL enc_k16 got=%h want=cb3d8b0e17f5", obs_k[15]); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== ref_k[i]) begin failures++; $display("FAIL enc_key[%0d] got=%h want=%h", i, obs_k[i], ref_k[i]); end
        end
        checks++; if (!idx_ok) begin failures++; $display("FAIL enc_round_idx got=bad want=0..15"); end
        checks++; if (done_c !== 17) begin failures++; $display("FAIL enc_done_cycle got=%0d want=17", done_c); end
        checks++; if (busy_at_done !== 1'b0 || valid_at_done !== 1'b0) begin failures++; $display("FAIL enc_idle_at_done got=busy%b valid%b want=0 0", busy_at_done, valid_at_done); end
        checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL enc_done_pulse got=%b want=0", done_after); end
    endtask

    task automatic test_decrypt;
        compute_ref(KEY_A);
        drive_stream(KEY_A, 1'b1, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (timed_out || done_c !== 17) begin failures++; $display("FAIL dec_done_cycle got=%0d want=17", done_c); end
        checks++; if (obs_k[0] !== 48'hCB3D8B0E17F5) begin failures++; $display("FAIL dec_k16 got=%h want=cb3d8b0e17f5", obs_k[0]); end
        checks++; if (obs_k[1] !== 48'hBF918D3D3F0A) begin failures++; $display("FAIL dec_k15 got=%h want=bf918d3d3f0a", obs_k[1]); end
        checks++; if (obs_k[15] !== 48'h1B02EFFC7072) begin failures++; $display("FAIL dec_k1 got=%h want=1b02effc7072", obs_k[15]); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== ref_k[15 - i]) begin failures++; $display("FAIL dec_key[%0d] got=%h want=%h", i, obs_k[i], ref_k[15 - i]); end
        end
        checks++; if (!idx_ok) begin failures++; $display("FAIL dec_round_idx got=bad want=0..15"); end
    endtask

    task automatic test_stall;
        compute_ref(KEY_A);
        drive_stream(KEY_A, 1'b0, 1'b1, 3, 5, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (!stall_ok) begin failures++; $display("FAIL stall_hold got=changed want=stable"); end
        checks++; if (timed_out || done_c !== 22) begin failures++; $display("FAIL stall_done_cycle got=%0d want=22", done_c); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== ref_k[i]) begin failures++; $display("FAIL stall_key[%0d] got=%h want=%h", i, obs_k[i], ref_k[i]); end
        end
        checks++; if (!idx_ok || obs_n !== 16) begin failures++; $display("FAIL stall_idx got=n%0d want=16", obs_n); end
    endtask

    task automatic test_start_while_busy;
        compute_ref(KEY_A);
        drive_stream(KEY_A, 1'b0, 1'b1, -1, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (timed_out || done_c !== 17) begin failures++; $display("FAIL busy_start_done got=%0d want=17", done_c); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== ref_k[i]) begin failures++; $display("FAIL busy_start_key[%0d] got=%h want=%h", i, obs_k[i], ref_k[i]); end
        end
        checks++; if (done_after !== 1'b0) begin failures++; $display("FAIL busy_start_restart got=done%b want=0", done_after); end
    endtask

    task automatic test_reset_mid_stream;
        logic [63:0] key;
        logic        md;
        int          n;
        bit          hit;
        compute_ref(KEY_A);
        bus.start = 1'b1; bus.mode = 1'b0; bus.key64 = KEY_A; bus.next = 1'b0;
        hit = 0; n = 0;
        while (n < 40 && !hit) begin
            @(posedge clk); #1;
            n++;
            bus.start = 1'b0;
            if (bus.subkey_valid && bus.round_idx == 4'd9) begin
                hit = 1; bus.next = 1'b0; rst_n = 1'b0;
            end else begin
                bus.next = 1'b1;
            end
        end
        checks++; if (!hit) begin failures++; $display("FAIL rst_mid_reach got=no_idx9 want=idx9"); end
        @(posedge clk); #1;
        checks++; if (bus.subkey_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_state got=valid%b busy%b want=0 0", bus.subkey_valid, bus.busy); end
        checks++; if (bus.subkey !== 48'h0 || bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_out got=%h done%b want=0 0", bus.subkey, bus.done); end
        rst_n = 1'b1;
        key = {$urandom, $urandom};
        md  = 1'($urandom_range(0, 1));
        compute_ref(key);
        drive_stream(key, md, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (timed_out || done_c !== 17) begin failures++; $display("FAIL rst_mid_restart_done got=%0d want=17", done_c); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== (md ? ref_k[15 - i] : ref_k[i])) begin failures++; $display("FAIL rst_mid_key[%0d] got=%h want=%h", i, obs_k[i], md ? ref_k[15 - i] : ref_k[i]); end
        end
    endtask

    task automatic test_back_to_back_parity;
        compute_ref(KEY_A);
        drive_stream(KEY_P, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, KEY_P, 1'b1);
        checks++; if (timed_out || done_c !== 17) begin failures++; $display("FAIL parity_enc_done got=%0d want=17", done_c); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== ref_k[i]) begin failures++; $display("FAIL parity_enc_key[%0d] got=%h want=%h", i, obs_k[i], ref_k[i]); end
        end
        drive_stream(KEY_P, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++; if (first_valid !== 1'b1) begin failures++; $display("FAIL b2b_accept got=valid%b want=1", first_valid); end
        checks++; if (timed_out || done_c !== 17) begin failures++; $display("FAIL parity_dec_done got=%0d want=17", done_c); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (obs_k[i] !== ref_k[15 - i]) begin failures++; $display("FAIL parity_dec_key[%0d] got=%h want=%h", i, obs_k[i], ref_k[15 - i]); end
        end
    endtask

    task automatic test_random;
        logic [63:0] key;
        logic        md;
        int          bad, first_bad;
        for (int it = 0; it < 8; it++) begin
            key = {$urandom, $urandom};
            md  = 1'($urandom_range(0, 1));
            compute_ref(key);
            drive_stream(key, md, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
            bad = 0; first_bad = -1;
            for (int i = 0; i < 16; i++) begin
                if (obs_k[i] !== (md ? ref_k[15 - i] : ref_k[i])) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            checks++; if (timed_out || obs_n !== 16) begin failures++; $display("FAIL rand%0d_count got=%0d want=16", it, obs_n); end
            checks++; if (bad !== 0) begin failures++; $display("FAIL rand%0d_keys got=%0d_wrong_first_%0d want=0_wrong key=%h mode=%b", it, bad, first_bad, key, md); end
            checks++; if (!idx_ok) begin failures++; $display("FAIL rand%0d_idx got=bad want=0..15", it); end
        end
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_stall;
        test_start_while_busy;
        test_reset_mid_stream;
        test_back_to_back_parity;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
